dmux_route_ctrl: RTL and testbench
==================================

DMUX_ROUTE_CTRL -- requirements
Module: dmux_route_ctrl

Interface
REQ-001: Parameter DATA_WIDTH, default 32, sets the stream data width in bits.
REQ-002: Parameter LEN_WIDTH, default 8, sets the burst length field width; a burst is cmd_len+1 beats.
REQ-003: The block SHALL use one clock and a synchronous, active-high reset.
REQ-004: clk  input  1  clock; all state updates on the rising edge.
REQ-005: rst  input  1  synchronous active-high reset.
REQ-006: cmd_valid  input  1  burst command valid.
REQ-007: cmd_ready  output  1  burst command accepted when high with cmd_valid.
REQ-008: cmd_dst  input  1  destination of the burst: 0 = port m0, 1 = port m1.
REQ-009: cmd_len  input  LEN_WIDTH  burst beats minus one.
REQ-010: s_valid, s_ready, s_last  input/output/input  1 each  upstream stream handshake and last flag.
REQ-011: s_data  input  DATA_WIDTH  upstream data.
REQ-012: m0_valid, m0_ready, m0_last  output/input/output  1 each  destination 0 handshake.
REQ-013: m0_data  output  DATA_WIDTH  destination 0 data.
REQ-014: m1_valid, m1_ready, m1_last, m1_data  same as m0, for destination 1.
REQ-015: sel  output  1  registered route select driven to the 1-to-2 data demux.
REQ-016: busy  output  1  high while a burst is being routed.
REQ-017: len_err  output  1  one-cycle pulse on an s_last/length mismatch.

Function
REQ-018: FSM states SHALL be IDLE and ROUTE only.
REQ-019: IDLE: cmd_ready=1, s_ready=0, m0_valid=m1_valid=0, busy=0.
REQ-020: IDLE with cmd_valid=1: latch dst_q=cmd_dst, cnt_q=cmd_len, sel=cmd_dst; enter ROUTE next cycle.
REQ-021: ROUTE: cmd_ready=0, busy=1; no new command accepted until return to IDLE (one-cycle bubble between bursts).
REQ-022: ROUTE, dst_q=d: md_valid=s_valid, s_ready=md_ready, md_data=s_data, md_last=(cnt_q==0), all combinational (zero-latency passthrough).
REQ-023: Inactive destination SHALL see valid=0, last=0, data all-zero at all times.
REQ-024: Beat transfer = s_valid && s_ready in ROUTE; on transfer with cnt_q!=0, cnt_q decrements by 1.
REQ-025: Transfer with cnt_q==0 ends the burst; next state IDLE, sel holds its value.
REQ-026: Burst length is counter-driven; s_last never terminates or extends a burst.
REQ-027: len_err SHALL pulse high for exactly the cycle after a transfer where s_last != (cnt_q==0); otherwise 0.
REQ-028: cmd_len=0 yields a single-beat burst with md_last=1 on that beat.
REQ-029: cmd_len=all-ones yields 2^LEN_WIDTH beats; the counter never wraps below zero.
REQ-030: Destination stall (md_ready=0) SHALL hold cnt_q and state; s_ready=0 propagates upstream the same cycle.
REQ-031: A cmd_dst or cmd_len change while in ROUTE SHALL have no effect.

Reset
REQ-032: With rst=1 at a clock edge: state=IDLE, cnt_q=0, dst_q=0, sel=0, len_err=0; next cycle cmd_ready=1, busy=0, s_ready=0.
REQ-033: Reset in ROUTE SHALL abort the burst; remaining beats are not routed and no len_err is raised.
REQ-034: rst SHALL take priority over a simultaneous command or beat transfer.

Verification
REQ-035: Reset, then cmd dst=0 len=3, 4 beats with s_last on the 4th, m0_ready=1 -> 4 beats on m0, m0_last only on beat 4, m1_valid=0 throughout, len_err=0, busy low one cycle after beat 4.
REQ-036: cmd dst=1 len=0, one beat with s_last=1 -> single beat on m1 with m1_last=1, sel=1, m0_data=0.
REQ-037: cmd dst=0 len=2; m0_ready toggles 1,0,0,1,1 -> s_ready mirrors m0_ready, exactly 3 transfers, counter held during stalls.
REQ-038: cmd len=1, s_last=1 on beat 1 -> len_err pulses after beat 1, burst still ends after beat 2.
REQ-039: cmd dst=1 len=7, rst asserted after beat 3 -> next cycle state IDLE, sel=0, cmd_ready=1, m1_valid=0, len_err=0.
REQ-040: Back-to-back commands dst=0 then dst=1, cmd_valid held -> second cmd_ready one cycle after first burst ends, no beat from burst 2 on m0.

Source files
------------

// File: rtl/dmux_route_ctrl.sv
// Burst router: accepts a (destination, length) command, then passes cmd_len+1
// beats from the upstream stream to m0 or m1 with zero latency.
module dmux_route_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_dst,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_last,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m0_valid,
   input  logic                  m0_ready,
   output logic                  m0_last,
   output logic [DATA_WIDTH-1:0] m0_data,
   output logic                  m1_valid,
   input  logic                  m1_ready,
   output logic                  m1_last,
   output logic [DATA_WIDTH-1:0] m1_data,
   output logic                  sel,
   output logic                  busy,
   output logic                  len_err,
   output logic                  dbg_state_o
);

   // Handshakes: a beat moves on a cycle where valid && ready are both high;
   // valid never waits on ready, and ready may depend combinationally on valid.
   typedef enum logic {
      IDLE  = 1'b0,
      ROUTE = 1'b1
   } state_e;

   state_e               state_q;
   logic [LEN_WIDTH-1:0] cnt_q;
   logic                 dst_q;
   logic                 sel_q;
   logic                 len_err_q;

   logic route;
   logic last_beat;
   logic xfer;
   logic len_err_d;
   logic to_m0;
   logic to_m1;

   assign route     = (state_q == ROUTE);
   assign last_beat = (cnt_q == '0);
   assign to_m0     = route && !dst_q;
   assign to_m1     = route && dst_q;

   assign s_ready   = (to_m0 && m0_ready) || (to_m1 && m1_ready);
   assign xfer      = s_valid && s_ready;
   assign len_err_d = xfer && (s_last != last_beat);

   assign m0_valid  = to_m0 && s_valid;
   assign m0_last   = to_m0 && last_beat;
   assign m0_data   = to_m0 ? s_data : '0;
   assign m1_valid  = to_m1 && s_valid;
   assign m1_last   = to_m1 && last_beat;
   assign m1_data   = to_m1 ? s_data : '0;

   assign cmd_ready   = !route;
   assign busy        = route;
   assign sel         = sel_q;
   assign len_err     = len_err_q;
   assign dbg_state_o = state_q;

   // s_last only feeds the error flag; the burst length comes from the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dst_q     <= 1'b0;
         sel_q     <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         len_err_q <= len_err_d;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  dst_q   <= cmd_dst;
                  cnt_q   <= cmd_len;
                  sel_q   <= cmd_dst;
                  state_q <= ROUTE;
               end
            end
            ROUTE: begin
               if (xfer) begin
                  if (last_beat) begin
                     state_q <= IDLE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmux_route_ctrl.sv
// Directed bench for dmux_route_ctrl: single/multi-beat bursts, stalls,
// length errors, reset abort, back-to-back commands and a full-length burst.
module tb_dmux_route_ctrl;

   localparam int DW = 32;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_dst;
   logic [LW-1:0] cmd_len;
   logic          s_valid, s_ready, s_last;
   logic [DW-1:0] s_data;
   logic          m0_valid, m0_ready, m0_last;
   logic [DW-1:0] m0_data;
   logic          m1_valid, m1_ready, m1_last;
   logic [DW-1:0] m1_data;
   logic          sel, busy, len_err, dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmux_route_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_last(m0_last), .m0_data(m0_data),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_last(m1_last), .m1_data(m1_data),
      .sel(sel), .busy(busy), .len_err(len_err), .dbg_state_o(dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0; cmd_dst = 1'b0; cmd_len = '0;
      s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      m0_ready = 1'b0; m1_ready = 1'b0;
   endtask

   task automatic issue_cmd(input logic dst, input logic [LW-1:0] len);
      cmd_valid = 1'b1; cmd_dst = dst; cmd_len = len;
      settle();
      check("cmd_ready_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      settle();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_sel", sel, 0);
      check("rst_len_err", len_err, 0);
      check("rst_state", dbg_state, 0);

      // 4-beat burst to m0
      issue_cmd(1'b0, 8'd3);
      check("t1_busy", busy, 1);
      check("t1_cmd_ready", cmd_ready, 0);
      m0_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = 32'hA0 + i; s_last = (i == 3);
         settle();
         check("t1_m0_valid", m0_valid, 1);
         check("t1_m0_data", m0_data, 32'hA0 + i);
         check("t1_m0_last", m0_last, (i == 3));
         check("t1_m1_valid", m1_valid, 0);
         check("t1_m1_data", m1_data, 0);
         check("t1_len_err", len_err, 0);
         tick();
      end
      s_valid = 1'b0; s_last = 1'b0;
      settle();
      check("t1_busy_end", busy, 0);
      check("t1_len_err_end", len_err, 0);

      // single beat to m1
      idle_inputs();
      issue_cmd(1'b1, 8'd0);
      check("t2_sel", sel, 1);
      m1_ready = 1'b1; s_valid = 1'b1; s_data = 32'h55; s_last = 1'b1;
      settle();
      check("t2_m1_valid", m1_valid, 1);
      check("t2_m1_last", m1_last, 1);
      check("t2_m1_data", m1_data, 32'h55);
      check("t2_m0_data", m0_data, 0);
      check("t2_m0_valid", m0_valid, 0);
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      settle();
      check("t2_busy_end", busy, 0);
      check("t2_sel_hold", sel, 1);

      // m0 stalls: ready 1,0,0,1,1 -> transfers on cycles 0,3,4
      idle_inputs();
      issue_cmd(1'b0, 8'd2);
      begin
         logic [4:0] rdy_pat;
         logic [4:0] last_pat;
         int beat;
         rdy_pat  = 5'b11001;  // bit k = cycle k
         last_pat = 5'b10000;
         beat = 0;
         for (int k = 0; k < 5; k++) begin
            m0_ready = rdy_pat[k]; s_valid = 1'b1; s_data = 32'hC0 + beat;
            s_last = (beat == 2);
            settle();
            check("t3_s_ready", s_ready, rdy_pat[k]);
            check("t3_m0_last", m0_last, last_pat[k]);
            check("t3_m0_data", m0_data, 32'hC0 + beat);
            check("t3_busy", busy, 1);
            check("t3_len_err", len_err, 0);
            if (rdy_pat[k]) beat++;
            tick();
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      settle();
      check("t3_busy_end", busy, 0);

      // early s_last on beat 1 of a 2-beat burst
      idle_inputs();
      issue_cmd(1'b0, 8'd1);
      m0_ready = 1'b1; s_valid = 1'b1; s_data = 32'h11; s_last = 1'b1;
      settle();
      check("t4_m0_last_b1", m0_last, 0);
      tick();
      s_data = 32'h22; s_last = 1'b1;
      settle();
      check("t4_len_err_pulse", len_err, 1);
      check("t4_busy_b2", busy, 1);
      check("t4_m0_last_b2", m0_last, 1);
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      settle();
      check("t4_len_err_clr", len_err, 0);
      check("t4_busy_end", busy, 0);

      // reset mid-burst, with command inputs changing while routing
      idle_inputs();
      issue_cmd(1'b1, 8'd7);
      m1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = 32'hE0 + i; s_last = 1'b0;
         if (i == 1) begin
            cmd_valid = 1'b1; cmd_dst = 1'b0; cmd_len = 8'd0;
         end
         settle();
         check("t5_m1_valid", m1_valid, 1);
         check("t5_sel", sel, 1);
         check("t5_m1_last", m1_last, 0);
         tick();
      end
      rst = 1'b1; cmd_valid = 1'b1;
      tick();
      settle();
      check("t5_state", dbg_state, 0);
      check("t5_sel_rst", sel, 0);
      check("t5_cmd_ready", cmd_ready, 1);
      check("t5_m1_valid_rst", m1_valid, 0);
      check("t5_len_err", len_err, 0);
      tick();
      settle();
      check("t5_rst_over_cmd", busy, 0);
      rst = 1'b0;
      idle_inputs();

      // back-to-back: dst0 len1 then dst1 len0, cmd_valid held
      cmd_valid = 1'b1; cmd_dst = 1'b0; cmd_len = 8'd1;
      tick();
      cmd_dst = 1'b1; cmd_len = 8'd0;
      m0_ready = 1'b1; m1_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s_valid = 1'b1; s_data = 32'hB0 + i; s_last = (i == 1);
         settle();
         check("t6_cmd_ready_busy", cmd_ready, 0);
         check("t6_m0_valid", m0_valid, 1);
         check("t6_m1_valid", m1_valid, 0);
         tick();
      end
      s_data = 32'hBF; s_last = 1'b1;
      settle();
      check("t6_bubble_ready", cmd_ready, 1);
      check("t6_bubble_m0", m0_valid, 0);
      check("t6_bubble_s_ready", s_ready, 0);
      tick();
      cmd_valid = 1'b0;
      settle();
      check("t6_b2_sel", sel, 1);
      check("t6_b2_m0_valid", m0_valid, 0);
      check("t6_b2_m1_valid", m1_valid, 1);
      check("t6_b2_m1_last", m1_last, 1);
      check("t6_b2_m1_data", m1_data, 32'hBF);
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      settle();
      check("t6_busy_end", busy, 0);

      // full-length burst: 256 beats, last only on the final beat
      idle_inputs();
      issue_cmd(1'b0, 8'hFF);
      m0_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         s_valid = 1'b1; s_data = i; s_last = (i == 255);
         settle();
         check("t7_m0_last", m0_last, (i == 255));
         if (i == 0 || i == 255) check("t7_busy", busy, 1);
         tick();
      end
      s_valid = 1'b0; s_last = 1'b0;
      settle();
      check("t7_busy_end", busy, 0);
      check("t7_len_err", len_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
